// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl
//  Description : Push-button front end for an up/down counter. Synchronises
//                and debounces two raw buttons, arbitrates simultaneous
//                presses, auto-repeats while a key is held, guards the count
//                limits and issues single-cycle inc/dec pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_RATE   = 10_000_000,
    parameter int CNT_W      = 7,
    parameter int CNT_MAX    = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic [CNT_W-1:0] count,
    output logic             inc,
    output logic             dec,
    output logic [1:0]       state
);

    localparam int c_DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int c_TMR_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_DEB_W-1:0] c_DEB_LAST  = c_DEB_W'(DEB_CYCLES);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE   = c_DEB_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_DELAY = c_TMR_W'(RPT_DELAY);
    localparam logic [c_TMR_W-1:0] c_TMR_RATE  = c_TMR_W'(RPT_RATE);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]   c_CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD_INC = 2'd1,
        ST_HOLD_DEC = 2'd2,
        ST_LOCK     = 2'd3
    } state_t;

    // Index 0 is the increment button, index 1 the decrement button.
    logic [1:0] w_raw;
    logic [1:0] w_deb;
    logic [1:0] r_deb_d;

    assign w_raw = {btn_dec, btn_inc};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_btn
            logic               r_meta;
            logic               r_sync;
            logic               r_level;
            logic [c_DEB_W-1:0] r_cnt;

            // Two-flop synchroniser followed by a run-length debouncer: the
            // level flips on the sample after DEB_CYCLES differing samples.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_meta  <= 1'b0;
                    r_sync  <= 1'b0;
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_meta <= w_raw[i];
                    r_sync <= r_meta;
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DEB_ONE;
                    end
                end
            end

            assign w_deb[i] = r_level;
        end
    endgenerate

    logic w_di, w_dd, w_di_rise, w_dd_rise;

    assign w_di      = w_deb[0];
    assign w_dd      = w_deb[1];
    assign w_di_rise = w_deb[0] & ~r_deb_d[0];
    assign w_dd_rise = w_deb[1] & ~r_deb_d[1];

    state_t             r_state, w_state_next;
    logic [c_TMR_W-1:0] r_timer, w_timer_next;
    logic               w_inc_req, w_dec_req;
    logic               r_inc, r_dec;

    // Registers: FSM state, repeat timer, edge-detect history and the
    // limit-guarded output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_deb_d <= 2'b00;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_deb_d <= w_deb;
            r_inc   <= w_inc_req && (count < c_CNT_MAX);
            r_dec   <= w_dec_req && (count != c_CNT_ZERO);
        end
    end

    // Next-state, timer and pulse-request logic. A timer value of 1 means
    // it reaches zero on this edge, so the repeat pulse is issued now.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_inc_req    = 1'b0;
        w_dec_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_di && w_dd) begin
                    w_state_next = ST_LOCK;
                end else if (w_di_rise) begin
                    w_inc_req    = 1'b1;
                    w_timer_next = c_TMR_DELAY;
                    w_state_next = ST_HOLD_INC;
                end else if (w_dd_rise) begin
                    w_dec_req    = 1'b1;
                    w_timer_next = c_TMR_DELAY;
                    w_state_next = ST_HOLD_DEC;
                end
            end
            ST_HOLD_INC: begin
                if (r_timer != '0) begin
                    w_timer_next = r_timer - c_TMR_ONE;
                end
                if (!w_di) begin
                    w_state_next = ST_IDLE;
                end else if (w_dd) begin
                    w_state_next = ST_LOCK;
                end else if (r_timer == c_TMR_ONE) begin
                    w_inc_req    = 1'b1;
                    w_timer_next = c_TMR_RATE;
                end
            end
            ST_HOLD_DEC: begin
                if (r_timer != '0) begin
                    w_timer_next = r_timer - c_TMR_ONE;
                end
                if (!w_dd) begin
                    w_state_next = ST_IDLE;
                end else if (w_di) begin
                    w_state_next = ST_LOCK;
                end else if (r_timer == c_TMR_ONE) begin
                    w_dec_req    = 1'b1;
                    w_timer_next = c_TMR_RATE;
                end
            end
            ST_LOCK: begin
                if (!w_di && !w_dd) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign inc   = r_inc;
    assign dec   = r_dec;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_ctrl
//  Description : Scoreboard bench for counter_ctrl. Directed button
//                sequences push expected pulses (cycle, direction) into a
//                queue; a monitor pops and compares on every DUT pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int DEB  = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;
    localparam int W    = 7;
    localparam int MAXC = 99;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         btn_inc = 1'b0;
    logic         btn_dec = 1'b0;
    logic [W-1:0] count   = 7'd5;
    logic         inc;
    logic         dec;
    logic [1:0]   state;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cyc[$];
    bit exp_is_inc[$];

    counter_ctrl #(
        .DEB_CYCLES(DEB),
        .RPT_DELAY (DLY),
        .RPT_RATE  (RATE),
        .CNT_W     (W),
        .CNT_MAX   (MAXC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .count  (count),
        .inc    (inc),
        .dec    (dec),
        .state  (state)
    );

    always #5 clk = ~clk;

    // Cycle index: the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_pulse(input int c, input bit is_inc);
        exp_cyc.push_back(c);
        exp_is_inc.push_back(is_inc);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_cyc.size(), 0);
        exp_cyc.delete();
        exp_is_inc.delete();
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    task automatic monitor();
        int ec;
        bit ei;
        forever begin
            @(negedge clk);
            if (inc && dec) check("exclusive", 1, 0);
            if (inc || dec) begin
                if (exp_cyc.size() == 0) begin
                    check(inc ? "unexpected_inc" : "unexpected_dec", cyc, -1);
                end else begin
                    ec = exp_cyc.pop_front();
                    ei = exp_is_inc.pop_front();
                    check(ei ? "inc_cycle" : "dec_cycle", cyc, ec);
                    check("pulse_dir", int'(inc), int'(ei));
                end
            end
        end
    endtask

    initial begin
        int k;
        int r;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_inc", int'(inc), 0);
        check("rst_dec", int'(dec), 0);
        check("rst_state", int'(state), 0);
        reset = 1'b0;

        // T1: reset while auto-repeating, button still held afterwards
        at(cyc + 2);
        k = cyc;
        count   = 7'd5;
        btn_inc = 1'b1;
        expect_pulse(k + 8, 1'b1);
        expect_pulse(k + 18, 1'b1);
        expect_pulse(k + 21, 1'b1);
        at(k + 12);
        check("t1_state_hold", int'(state), 1);
        at(k + 22);
        check("t1_state_pre_rst", int'(state), 1);
        #2 reset = 1'b1;
        #1;
        check("t1_async_inc", int'(inc), 0);
        check("t1_async_dec", int'(dec), 0);
        check("t1_async_state", int'(state), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        expect_pulse(r + 8, 1'b1);
        at(r + 9);
        btn_inc = 1'b0;
        at(r + 20);
        check("t1_state_idle", int'(state), 0);
        drain_check("t1_queue");

        // T2: single press, released before the first repeat
        k = cyc;
        count   = 7'd5;
        btn_inc = 1'b1;
        expect_pulse(k + 8, 1'b1);
        at(k + 9);
        btn_inc = 1'b0;
        at(k + 10);
        check("t2_state_hold", int'(state), 1);
        at(k + 20);
        check("t2_state_idle", int'(state), 0);
        drain_check("t2_queue");

        // T3: bounce then settle high, count one below the limit
        k = cyc;
        count = 7'd98;
        for (int i = 0; i < 6; i++) begin
            at(k + 2 * i);
            btn_inc = (i % 2 == 0);
        end
        at(k + 12);
        btn_inc = 1'b1;
        expect_pulse(k + 20, 1'b1);
        at(k + 19);
        check("t3_idle_before", int'(state), 0);
        at(k + 21);
        btn_inc = 1'b0;
        at(k + 32);
        check("t3_state_idle", int'(state), 0);
        drain_check("t3_queue");

        // T4: decrement held, first repeat after DLY then every RATE
        k = cyc;
        count   = 7'd50;
        btn_dec = 1'b1;
        expect_pulse(k + 8, 1'b0);
        for (int t = 8 + DLY; t <= 45; t += RATE) expect_pulse(k + t, 1'b0);
        at(k + 9);
        check("t4_state_a", int'(state), 2);
        at(k + 40);
        check("t4_state_b", int'(state), 2);
        btn_dec = 1'b0;
        at(k + 46);
        check("t4_state_c", int'(state), 2);
        at(k + 50);
        check("t4_state_idle", int'(state), 0);
        drain_check("t4_queue");

        // T5: limit guard at the top and bottom of the range
        k = cyc;
        count   = 7'd99;
        btn_inc = 1'b1;
        at(k + 12);
        check("t5_state_inc", int'(state), 1);
        at(k + 26);
        btn_inc = 1'b0;
        at(k + 36);
        check("t5_idle_a", int'(state), 0);
        k = cyc;
        count   = 7'd0;
        btn_dec = 1'b1;
        at(k + 12);
        check("t5_state_dec", int'(state), 2);
        at(k + 26);
        btn_dec = 1'b0;
        at(k + 36);
        check("t5_idle_b", int'(state), 0);
        drain_check("t5_queue");

        // T6: simultaneous press locks until both keys are released
        k = cyc;
        count   = 7'd50;
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        at(k + 10);
        check("t6_lock", int'(state), 3);
        at(k + 12);
        btn_dec = 1'b0;
        at(k + 22);
        check("t6_lock_one_held", int'(state), 3);
        btn_inc = 1'b0;
        at(k + 32);
        check("t6_idle", int'(state), 0);
        drain_check("t6_queue");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
